disk_uart_port: RTL and testbench

- Memory-mapped serial "disk" port on the shared 32-bit CPU data bus, mapped to the 0xD region.
- The parent decodes Addr[31:28]==4'hD and passes gated Memread/Memwrite strobes.
- The block converts bus reads/writes into 8N1 UART traffic on TxD/RxD toward a host-side disk server.
- Received bytes are buffered in an RX FIFO.

---
 rtl/disk_uart_port.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_disk_uart_port.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disk_uart_port.sv
// ---------------------------------------------------------------------------
// disk_uart_port
//
// Memory-mapped serial "disk" port on the shared 32-bit CPU bus (0xD region).
// CPU reads and writes are turned into 8N1 UART traffic toward a host-side
// disk server. Received bytes are queued in a small RX FIFO.
//
// Ports
//   clk          : system clock, rising edge only
//   rst          : asynchronous reset, active low
//   BUS          : shared data bus; driven only while Memread=1, else Z
//   Memread      : read strobe (already chip-select gated, many cycles long)
//   Memwrite     : write strobe (already chip-select gated, many cycles long)
//   Addrin       : byte address, only Addrin[3:2] is decoded
//   TxD          : UART transmit, idle high, registered
//   RxD          : UART receive, asynchronous to clk
//   tx_state_dbg : current TX engine state
//   rx_state_dbg : current RX engine state
//
// Register map (Addrin[3:2])
//   0 DATA   : read  {23'b0, rx_valid, rx_head}, pops the FIFO when the
//              read strobe ends; write starts a transmission if TX is idle
//   1 STATUS : read  {19'b0, rx_count[4:0], 3'b0, frame_err, overrun,
//              tx_busy, rx_valid}; clears frame_err/overrun when the read
//              strobe ends
//   2,3      : read 0, writes ignored
//
// Bus handshake: the strobes are level signals held for many cycles. Read
// data is presented combinationally for the whole time Memread is high.
// Side effects happen exactly once per access: a write acts on the cycle
// Memwrite rises, a read acts on the cycle Memread falls (using the address
// that was present while it was high). There is no ready/back-pressure:
// a DATA write arriving while TX is busy is silently dropped.
// ---------------------------------------------------------------------------
module disk_uart_port #(
    parameter int BAUD_DIV = 434,
    parameter int RX_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] BUS,
    input  logic        Memread,
    input  logic        Memwrite,
    input  logic [31:0] Addrin,
    output logic        TxD,
    input  logic        RxD,
    output logic [0:0]  tx_state_dbg,
    output logic [1:0]  rx_state_dbg
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int HALF  = BAUD_DIV / 2;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(RX_DEPTH);

    typedef enum logic {TX_IDLE, TX_RUN} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Upper/lower address bits are not decoded
    logic unused_addr;
    assign unused_addr = ^{Addrin[31:4], Addrin[1:0]};

    // ---------------------------------------------------------------- strobes
    logic       memread_q;
    logic       memwrite_q;
    logic [1:0] rd_addr_q;
    logic       rd_fall;
    logic       wr_rise;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            rd_addr_q  <= 2'd0;
        end else begin
            memread_q  <= Memread;
            memwrite_q <= Memwrite;
            if (Memread) rd_addr_q <= Addrin[3:2];
        end
    end

    assign rd_fall = memread_q && !Memread;
    assign wr_rise = Memwrite && !memwrite_q;

    // ---------------------------------------------------------------- TX engine
    tx_state_t        tx_state;
    tx_state_t        tx_state_next;
    logic [CNT_W-1:0] tx_baud_cnt;
    logic [3:0]       tx_bit_cnt;
    logic [9:0]       tx_shift;
    logic             txd_q;
    logic             tx_load;
    logic             tx_done;
    logic             tx_baud_end;
    logic             tx_busy;

    assign tx_baud_end = (tx_baud_cnt == BAUD_LAST);
    assign tx_busy     = (tx_state == TX_RUN);

    always_comb begin
        tx_state_next = tx_state;
        tx_load       = 1'b0;
        tx_done       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (wr_rise && (Addrin[3:2] == 2'd0)) begin
                    tx_load       = 1'b1;
                    tx_state_next = TX_RUN;
                end
            end
            TX_RUN: begin
                if (tx_baud_end && (tx_bit_cnt == 4'd9)) begin
                    tx_done       = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    // Frame is held as {stop, data, start}; bit 0 is always on the line and
    // the register shifts right once per bit period, filling with idle 1s.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state    <= TX_IDLE;
            tx_baud_cnt <= '0;
            tx_bit_cnt  <= 4'd0;
            tx_shift    <= 10'h3FF;
            txd_q       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            if (tx_load) begin
                tx_shift    <= {1'b1, BUS[7:0], 1'b0};
                txd_q       <= 1'b0;
                tx_baud_cnt <= '0;
                tx_bit_cnt  <= 4'd0;
            end else if (tx_state == TX_RUN) begin
                if (tx_baud_end) begin
                    tx_baud_cnt <= '0;
                    tx_bit_cnt  <= tx_bit_cnt + 4'd1;
                    tx_shift    <= {1'b1, tx_shift[9:1]};
                    txd_q       <= tx_done ? 1'b1 : tx_shift[1];
                end else begin
                    tx_baud_cnt <= tx_baud_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign TxD          = txd_q;
    assign tx_state_dbg = tx_state;

    // ---------------------------------------------------------------- RX engine
    rx_state_t        rx_state;
    rx_state_t        rx_state_next;
    logic             rxd_s1;
    logic             rxd_s2;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit_cnt;
    logic [7:0]       rx_shift;
    logic             rx_baud_end;
    logic             rx_sample;
    logic             rx_stop_eval;

    assign rx_baud_end = (rx_cnt == BAUD_LAST);

    always_comb begin
        rx_state_next = rx_state;
        rx_sample     = 1'b0;
        rx_stop_eval  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rxd_s2) rx_state_next = RX_START;
            end
            RX_START: begin
                // Mid-start-bit check rejects short glitches
                if (rx_cnt == HALF_LAST) rx_state_next = rxd_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (rx_baud_end) begin
                    rx_sample = 1'b1;
                    if (rx_bit_cnt == 3'd7) rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_baud_end) begin
                    rx_stop_eval  = 1'b1;
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_s1     <= 1'b1;
            rxd_s2     <= 1'b1;
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_cnt <= 3'd0;
            rx_shift   <= 8'h00;
        end else begin
            rxd_s1   <= RxD;
            rxd_s2   <= rxd_s1;
            rx_state <= rx_state_next;
            if ((rx_state_next != rx_state) || rx_baud_end) rx_cnt <= '0;
            else if (rx_state != RX_IDLE)                   rx_cnt <= rx_cnt + CNT_W'(1);
            if (rx_state == RX_START)  rx_bit_cnt <= 3'd0;
            else if (rx_sample)        rx_bit_cnt <= rx_bit_cnt + 3'd1;
            if (rx_sample) rx_shift <= {rxd_s2, rx_shift[7:1]};
        end
    end

    assign rx_state_dbg = rx_state;

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   rx_count;
    logic             rx_valid;
    logic             fifo_full;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             overrun_set;
    logic             frame_set;
    logic             flags_clr;
    logic             overrun;
    logic             frame_err;

    assign rx_valid    = (rx_count != '0);
    assign fifo_full   = (rx_count == FULL_CNT);
    assign push_req    = rx_stop_eval && rxd_s2;
    assign push        = push_req && !fifo_full;
    assign overrun_set = push_req && fifo_full;
    assign frame_set   = rx_stop_eval && !rxd_s2;
    assign pop         = rd_fall && (rd_addr_q == 2'd0) && rx_valid;
    assign flags_clr   = rd_fall && (rd_addr_q == 2'd1);

    always_ff @(posedge clk) begin
        if (push) rx_mem[wr_ptr] <= rx_shift;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rx_count  <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   rx_count <= rx_count + (PTR_W + 1)'(1);
                2'b01:   rx_count <= rx_count - (PTR_W + 1)'(1);
                default: rx_count <= rx_count;
            endcase
            // A fresh error in the clearing cycle must not be lost
            overrun   <= (overrun   && !flags_clr) || overrun_set;
            frame_err <= (frame_err && !flags_clr) || frame_set;
        end
    end

    // ---------------------------------------------------------------- read mux
    logic [31:0] rd_data;
    logic [7:0]  rx_head;

    assign rx_head = rx_valid ? rx_mem[rd_ptr] : 8'h00;

    always_comb begin
        rd_data = 32'h0;
        case (Addrin[3:2])
            2'd0:    rd_data = {23'b0, rx_valid, rx_head};
            2'd1:    rd_data = {19'b0, 5'(rx_count), 3'b0, frame_err, overrun, tx_busy, rx_valid};
            default: rd_data = 32'h0;
        endcase
    end

    assign BUS = Memread ? rd_data : 32'bz;

endmodule

// File: tb/tb_disk_uart_port.sv
module tb_disk_uart_port;
  localparam int BAUD  = 16;
  localparam int DEPTH = 16;

  // ------------------------------------------------------------ clock/reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        memread  = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addrin   = 32'h0;
  logic        rxd      = 1'b1;
  logic        bus_en   = 1'b0;
  logic [31:0] bus_val  = 32'h0;
  wire  [31:0] bus;
  wire         txd;
  wire  [0:0]  tx_state_dbg;
  wire  [1:0]  rx_state_dbg;

  assign bus = bus_en ? bus_val : 32'bz;

  disk_uart_port #(.BAUD_DIV(BAUD), .RX_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .BUS          (bus),
    .Memread      (memread),
    .Memwrite     (memwrite),
    .Addrin       (addrin),
    .TxD          (txd),
    .RxD          (rxd),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------ reference model
  logic [7:0]  model_fifo[$];
  logic        model_ovr  = 1'b0;
  logic        model_ferr = 1'b0;
  int          tx_start   = -100000;

  logic [31:0] rd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  function automatic logic tx_busy_at(input int c);
    return (c >= tx_start) && (c < tx_start + 10 * BAUD);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a, input int c);
    logic [31:0] r;
    logic [4:0]  n;
    r = 32'h0;
    n = 5'(model_fifo.size());
    case (a)
      2'd0: if (model_fifo.size() > 0) r = {23'b0, 1'b1, model_fifo[0]};
      2'd1: r = {19'b0, n, 3'b0, model_ferr, model_ovr, tx_busy_at(c), n != 5'd0};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic do_read(input logic [1:0] a);
    @(posedge clk);
    #1;
    addrin = {4'hD, 24'($urandom), a, 2'b00};
    rd_exp_q.push_back(model_read(a, cyc + 1));
    memread = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    memread = 1'b0;
    if (a == 2'd0 && model_fifo.size() > 0) void'(model_fifo.pop_front());
    if (a == 2'd1) begin
      model_ovr  = 1'b0;
      model_ferr = 1'b0;
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    addrin   = {4'hD, 24'($urandom), a, 2'b00};
    bus_val  = {24'($urandom), d};
    bus_en   = 1'b1;
    memwrite = 1'b1;
    if (a == 2'd0 && !tx_busy_at(cyc + 1)) begin
      tx_exp_q.push_back(d);
      tx_start = cyc + 1;
    end
    repeat (4) @(posedge clk);
    #1;
    memwrite = 1'b0;
    bus_en   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (BAUD) @(posedge clk);
      #1;
    end
    rxd = 1'b1;
    if (stop) begin
      if (model_fifo.size() < DEPTH) model_fifo.push_back(d);
      else model_ovr = 1'b1;
    end else begin
      model_ferr = 1'b1;
    end
    repeat (8) @(posedge clk);
  endtask

  task automatic send_glitch(input int len);
    @(posedge clk);
    #1;
    rxd = 1'b0;
    repeat (len) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (30) @(posedge clk);
  endtask

  // ------------------------------------------------------------ scoreboard: bus reads
  int          rd_hold = 0;
  logic [31:0] rd_want;

  always @(negedge clk) begin
    if (memread) begin
      if (rd_hold == 1) begin
        checks++;
        if (rd_exp_q.size() == 0) begin
          errors++;
          $display("FAIL bus_read unexpected got %h", bus);
        end else begin
          rd_want = rd_exp_q.pop_front();
          if (bus !== rd_want) begin
            errors++;
            $display("FAIL bus_read addr %0d got %h expected %h", addrin[3:2], bus, rd_want);
          end
        end
      end
      rd_hold++;
    end else begin
      rd_hold = 0;
    end
  end

  // ------------------------------------------------------------ scoreboard: TX frames
  logic [9:0] tx_got;
  logic [9:0] tx_want;

  initial begin
    forever begin
      @(negedge clk);
      if (rst && txd == 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        tx_got[0] = txd;
        for (int j = 1; j < 10; j++) begin
          repeat (BAUD) @(negedge clk);
          tx_got[j] = txd;
        end
        checks++;
        if (tx_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_frame unexpected got %b", tx_got);
        end else begin
          tx_want = {1'b1, tx_exp_q.pop_front(), 1'b0};
          if (tx_got !== tx_want) begin
            errors++;
            $display("FAIL tx_frame got %b expected %b", tx_got, tx_want);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_val("txd_in_reset", 32'(txd), 32'h1);
    rst = 1'b1;
    repeat (3) @(posedge clk);

    // Reset state
    do_read(2'd1);
    do_read(2'd0);
    do_read(2'd2);

    // Transmit, busy window, dropped second write
    do_write(2'd0, 8'hA5);
    do_read(2'd1);
    repeat (40) @(posedge clk);
    do_write(2'd0, 8'h3C);
    do_write(2'd3, 8'h77);
    while (tx_busy_at(cyc)) @(posedge clk);
    repeat (3) @(posedge clk);
    do_read(2'd1);

    // Single receive, read back, pop
    send_frame(8'h5A, 1'b1);
    do_read(2'd1);
    do_read(2'd0);
    do_read(2'd1);
    do_read(2'd0);

    // Overrun: seventeen bytes into a sixteen-deep FIFO
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    do_read(2'd1);
    for (int i = 0; i < 16; i++) do_read(2'd0);
    do_read(2'd1);
    do_read(2'd1);
    do_read(2'd0);

    // Framing error and start-bit glitch
    send_frame(8'h77, 1'b0);
    do_read(2'd1);
    do_read(2'd1);
    send_glitch(4);
    do_read(2'd1);
    do_read(2'd0);

    // Randomized mix
    for (int it = 0; it < 24; it++) begin
      case ($urandom_range(0, 3))
        0: send_frame(8'($urandom), $urandom_range(0, 3) != 0);
        1: do_read(2'($urandom_range(0, 3)));
        2: do_write(2'($urandom_range(0, 1)), 8'($urandom));
        default: repeat ($urandom_range(1, 40)) @(posedge clk);
      endcase
    end
    while (model_fifo.size() > 0) do_read(2'd0);
    do_read(2'd1);
    do_read(2'd1);

    // Reset in the middle of a received frame
    while (tx_busy_at(cyc)) @(posedge clk);
    repeat (20) @(posedge clk);
    send_frame(8'h33, 1'b1);
    @(posedge clk);
    #1;
    rxd = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    rst = 1'b0;
    model_fifo.delete();
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("txd_mid_reset", 32'(txd), 32'h1);
    rxd = 1'b1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    do_read(2'd1);
    do_read(2'd0);

    // Drain: every expected response must have been consumed
    repeat (200) @(posedge clk);
    check_val("rd_queue_left", 32'(rd_exp_q.size()), 32'h0);
    check_val("tx_queue_left", 32'(tx_exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
